// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side and SRAM-side bundle of the SRAM arbiter.
// Ports: r0_*/r1_* requester command and read-return signals, sram_* pad-side
// command/data signals. slave = arbiter view, master = requesters + SRAM pads.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              r0_req, r0_we, r0_grant, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_we, r1_grant, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_xe1, sram_xwa, sram_oe;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  sram_rdata,
    output r0_grant, r0_rvalid, r0_rdata,
    output r1_grant, r1_rvalid, r1_rdata,
    output sram_addr, sram_xe1, sram_xwa, sram_wdata, sram_oe
  );
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output sram_rdata,
    input  r0_grant, r0_rvalid, r0_rdata,
    input  r1_grant, r1_rvalid, r1_rdata,
    input  sram_addr, sram_xe1, sram_xwa, sram_wdata, sram_oe
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and sequencer for a pipelined ZBT SRAM.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries both requester
// ports (req/we/addr/wdata in, grant/rvalid/rdata out) and the SRAM command/data pins.
module sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          reset,
  sram_arbiter_if.slave bus
);
  logic              g0, g1, rd_ret;
  logic              prio_q, prio_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              xe1_q, xe1_d, xwa_q, xwa_d;
  logic [2:0]        v_q, v_d, we_q, we_d, id_q, id_d;
  logic [DATA_W-1:0] wd0_q, wd0_d, wd1_q, wd1_d, swd_q, swd_d;
  logic [1:0]        rv_q, rv_d;
  logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  always_comb begin
    g0     = !reset && bus.r0_req && (!bus.r1_req || !prio_q);
    g1     = !reset && bus.r1_req && (!bus.r0_req || prio_q);
    prio_d = g0 ? 1'b1 : g1 ? 1'b0 : prio_q;
    addr_d = g0 ? bus.r0_addr : g1 ? bus.r1_addr : addr_q;
    xe1_d  = !(g0 || g1);
    xwa_d  = g0 ? !bus.r0_we : g1 ? !bus.r1_we : 1'b1;
    // Stage 0 holds the command during its address phase; stage 2 is the data phase.
    v_d    = {v_q[1:0], g0 || g1};
    we_d   = {we_q[1:0], g0 ? bus.r0_we : bus.r1_we};
    id_d   = {id_q[1:0], g1};
    wd0_d  = g0 ? bus.r0_wdata : bus.r1_wdata;
    wd1_d  = wd0_q;
    // Loaded one cycle early so the write data is on the pins during the data phase.
    swd_d  = (v_q[1] && we_q[1]) ? wd1_q : swd_q;
    rd_ret = v_q[2] && !we_q[2];
    rv_d   = {rd_ret && id_q[2], rd_ret && !id_q[2]};
    rd0_d  = rv_d[0] ? bus.sram_rdata : rd0_q;
    rd1_d  = rv_d[1] ? bus.sram_rdata : rd1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
      addr_q <= '0;
      xe1_q  <= 1'b1;
      xwa_q  <= 1'b1;
      v_q    <= '0;
      we_q   <= '0;
      id_q   <= '0;
      wd0_q  <= '0;
      wd1_q  <= '0;
      swd_q  <= '0;
      rv_q   <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      prio_q <= prio_d;
      addr_q <= addr_d;
      xe1_q  <= xe1_d;
      xwa_q  <= xwa_d;
      v_q    <= v_d;
      we_q   <= we_d;
      id_q   <= id_d;
      wd0_q  <= wd0_d;
      wd1_q  <= wd1_d;
      swd_q  <= swd_d;
      rv_q   <= rv_d;
      rd0_q  <= rd0_d;
      rd1_q  <= rd1_d;
    end
  end
  assign bus.r0_grant   = g0;
  assign bus.r1_grant   = g1;
  assign bus.r0_rvalid  = rv_q[0];
  assign bus.r1_rvalid  = rv_q[1];
  assign bus.r0_rdata   = rd0_q;
  assign bus.r1_rdata   = rd1_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_xe1   = xe1_q;
  assign bus.sram_xwa   = xwa_q;
  assign bus.sram_wdata = swd_q;
  assign bus.sram_oe    = v_q[2] && we_q[2];
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a fake ZBT SRAM.
module tb_sram_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  sram_arbiter_if #(.ADDR_W(20), .DATA_W(32)) bus ();
  sram_arbiter #(.ADDR_W(20), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0, n_err = 0;
  logic [31:0] fmem [0:1023];
  logic init_done = 1'b0, pl_we = 1'b0;
  logic [9:0] pl_a = '0;
  logic [31:0] pl_d = '0;
  logic s1v = 1'b0, s1w = 1'b0, s2v = 1'b0, s2w = 1'b0;
  logic [9:0] s1a = '0, s2a = '0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) fmem[i] <= 32'(i);
      init_done <= 1'b1;
    end else if (pl_we) fmem[pl_a] <= pl_d;
    else if (s2v && s2w && bus.sram_oe) fmem[s2a] <= bus.sram_wdata;
    s1v <= !bus.sram_xe1;
    s1w <= !bus.sram_xwa;
    s1a <= bus.sram_addr[9:0];
    s2v <= s1v;
    s2w <= s1w;
    s2a <= s1a;
  end
  assign bus.sram_rdata = (s2v && !s2w) ? fmem[s2a] : 32'h0;
  typedef struct { int due; logic id; logic [31:0] d; } rd_t;
  typedef struct { int due; logic [31:0] d; } wr_t;
  rd_t rq[$];
  wr_t wq[$];
  logic [31:0] rmem [0:15];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    bus.r0_req = 1'b1;
    bus.r1_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      #3;
      n_cmp++; if ({bus.r0_grant, bus.r1_grant} !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", {bus.r0_grant, bus.r1_grant}); end
    end
    tick;
    reset = 1'b0;
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    #3;
    n_cmp++; if ({bus.sram_xe1, bus.sram_xwa, bus.sram_oe, bus.r0_rvalid, bus.r1_rvalid} !== 5'b11000) begin n_err++; $display("FAIL reset_ctrl: got xe1/xwa/oe/rv0/rv1=%b want 11000", {bus.sram_xe1, bus.sram_xwa, bus.sram_oe, bus.r0_rvalid, bus.r1_rvalid}); end
    n_cmp++; if ({bus.sram_addr, bus.sram_wdata, bus.r0_rdata, bus.r1_rdata} !== '0) begin n_err++; $display("FAIL reset_data: got addr=%h wdata=%h rd0=%h rd1=%h want all 0", bus.sram_addr, bus.sram_wdata, bus.r0_rdata, bus.r1_rdata); end
  endtask
  task automatic test_single_read;
    pl_we = 1'b1; pl_a = 10'h10; pl_d = 32'hDEADBEEF;
    tick;
    pl_we = 1'b0;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 20'h10;
    #3;
    n_cmp++; if ({bus.r0_grant, bus.r1_grant} !== 2'b01) begin n_err++; $display("FAIL read_grant: got %b want 01", {bus.r0_grant, bus.r1_grant}); end
    for (int k = 1; k <= 6; k++) begin
      tick;
      bus.r1_req = 1'b0;
      #3;
      if (k == 1) begin
        n_cmp++; if ({bus.sram_xe1, bus.sram_xwa, bus.sram_addr} !== {2'b01, 20'h10}) begin n_err++; $display("FAIL read_cmd: got xe1=%b xwa=%b addr=%h want 0 1 00010", bus.sram_xe1, bus.sram_xwa, bus.sram_addr); end
      end
      n_cmp++; if (bus.r1_rvalid !== (k == 4)) begin n_err++; $display("FAIL read_rvalid k=%0d: got %b want %b", k, bus.r1_rvalid, k == 4); end
      if (k == 4) begin
        n_cmp++; if (bus.r1_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rdata: got %h want deadbeef", bus.r1_rdata); end
      end
      n_cmp++; if (bus.r0_rvalid !== 1'b0) begin n_err++; $display("FAIL read_other_rvalid k=%0d: got %b want 0", k, bus.r0_rvalid); end
    end
  endtask
  task automatic test_single_write;
    tick;
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 20'h5; bus.r0_wdata = 32'h12345678;
    #3;
    n_cmp++; if (bus.r0_grant !== 1'b1) begin n_err++; $display("FAIL write_grant: got %b want 1", bus.r0_grant); end
    for (int k = 1; k <= 5; k++) begin
      tick;
      bus.r0_req = 1'b0;
      #3;
      if (k == 1) begin
        n_cmp++; if ({bus.sram_xe1, bus.sram_xwa} !== 2'b00) begin n_err++; $display("FAIL write_cmd: got xe1/xwa=%b want 00", {bus.sram_xe1, bus.sram_xwa}); end
      end
      n_cmp++; if (bus.sram_oe !== (k == 3)) begin n_err++; $display("FAIL write_oe k=%0d: got %b want %b", k, bus.sram_oe, k == 3); end
      if (k == 3) begin
        n_cmp++; if (bus.sram_wdata !== 32'h12345678) begin n_err++; $display("FAIL write_wdata: got %h want 12345678", bus.sram_wdata); end
      end
    end
    tick;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 20'h5;
    #3;
    n_cmp++; if (bus.r0_grant !== 1'b1) begin n_err++; $display("FAIL readback_grant: got %b want 1", bus.r0_grant); end
    for (int k = 1; k <= 5; k++) begin
      tick;
      bus.r0_req = 1'b0;
      #3;
      if (k == 4) begin
        n_cmp++; if ({bus.r0_rvalid, bus.r0_rdata} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL readback: got rvalid=%b rdata=%h want 1 12345678", bus.r0_rvalid, bus.r0_rdata); end
      end
    end
  endtask
  task automatic test_contention;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 20'($urandom_range(0, 1023));
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 20'($urandom_range(0, 1023));
    for (int i = 0; i < 8; i++) begin
      #3;
      n_cmp++; if ({bus.r0_grant, bus.r1_grant} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL contention i=%0d: got %b want %b", i, {bus.r0_grant, bus.r1_grant}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      tick;
    end
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    repeat (6) tick;
  endtask
  task automatic test_streaming;
    for (int c = 0; c < 14; c++) begin
      bus.r0_req = (c < 8); bus.r0_we = 1'b0; bus.r0_addr = 20'(32'h100 + c);
      #3;
      if (c < 8) begin
        n_cmp++; if (bus.r0_grant !== 1'b1) begin n_err++; $display("FAIL stream_grant c=%0d: got %b want 1", c, bus.r0_grant); end
      end
      n_cmp++; if (bus.r0_rvalid !== (c >= 4 && c < 12)) begin n_err++; $display("FAIL stream_rvalid c=%0d: got %b want %b", c, bus.r0_rvalid, c >= 4 && c < 12); end
      if (c >= 4 && c < 12) begin
        n_cmp++; if (bus.r0_rdata !== 32'(32'h100 + c - 4)) begin n_err++; $display("FAIL stream_rdata c=%0d: got %h want %h", c, bus.r0_rdata, 32'h100 + c - 4); end
      end
      tick;
    end
  endtask
  task automatic test_back_to_back;
    int oe_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      bus.r1_req = (c < 2); bus.r1_we = (c == 0); bus.r1_addr = 20'h20; bus.r1_wdata = 32'hA5A5A5A5;
      #3;
      if (c < 2) begin
        n_cmp++; if (bus.r1_grant !== 1'b1) begin n_err++; $display("FAIL b2b_grant c=%0d: got %b want 1", c, bus.r1_grant); end
      end
      oe_cnt += int'(bus.sram_oe);
      if (c == 5) begin
        n_cmp++; if ({bus.r1_rvalid, bus.r1_rdata} !== {1'b1, 32'hA5A5A5A5}) begin n_err++; $display("FAIL b2b_read: got rvalid=%b rdata=%h want 1 a5a5a5a5", bus.r1_rvalid, bus.r1_rdata); end
      end
      tick;
    end
    n_cmp++; if (oe_cnt != 1) begin n_err++; $display("FAIL b2b_oe_count: got %0d want 1", oe_cnt); end
  endtask
  task automatic test_reset_midflight;
    for (int c = 0; c < 7; c++) begin
      bus.r0_req = (c == 0); bus.r0_we = 1'b0; bus.r0_addr = 20'h10;
      reset = (c == 2);
      #3;
      if (c == 0) begin
        n_cmp++; if (bus.r0_grant !== 1'b1) begin n_err++; $display("FAIL mid_grant: got %b want 1", bus.r0_grant); end
      end
      if (c >= 3) begin
        n_cmp++; if ({bus.sram_xe1, bus.sram_xwa, bus.sram_oe, bus.r0_rvalid, bus.r1_rvalid} !== 5'b11000) begin n_err++; $display("FAIL mid_ctrl c=%0d: got %b want 11000", c, {bus.sram_xe1, bus.sram_xwa, bus.sram_oe, bus.r0_rvalid, bus.r1_rvalid}); end
        n_cmp++; if ({bus.sram_addr, bus.sram_wdata, bus.r0_rdata, bus.r1_rdata} !== '0) begin n_err++; $display("FAIL mid_data c=%0d: got addr=%h wdata=%h rd0=%h rd1=%h want 0", c, bus.sram_addr, bus.sram_wdata, bus.r0_rdata, bus.r1_rdata); end
      end
      tick;
    end
    bus.r0_req = 1'b1;
    bus.r1_req = 1'b1;
    #3;
    n_cmp++; if ({bus.r0_grant, bus.r1_grant} !== 2'b10) begin n_err++; $display("FAIL mid_first_grant: got %b want 10", {bus.r0_grant, bus.r1_grant}); end
    tick;
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    repeat (6) tick;
  endtask
  task automatic test_random;
    logic p0 = 1'b0, p1 = 1'b0, turn = 1'b0, e0, e1;
    logic [1:0] erv;
    logic [31:0] ed;
    rd_t r;
    wr_t w;
    for (int i = 0; i < 16; i++) rmem[i] = 32'h200 + 32'(i);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int t = 0; t < 408; t++) begin
      if (!p0 && t < 400 && $urandom_range(0, 9) < 6) begin
        p0 = 1'b1; bus.r0_we = 1'($urandom_range(0, 1)); bus.r0_addr = 20'(32'h200 + $urandom_range(0, 15)); bus.r0_wdata = $urandom;
      end
      if (!p1 && t < 400 && $urandom_range(0, 9) < 6) begin
        p1 = 1'b1; bus.r1_we = 1'($urandom_range(0, 1)); bus.r1_addr = 20'(32'h200 + $urandom_range(0, 15)); bus.r1_wdata = $urandom;
      end
      bus.r0_req = p0;
      bus.r1_req = p1;
      #3;
      e0 = p0 && (!p1 || !turn);
      e1 = p1 && (!p0 || turn);
      n_cmp++; if ({bus.r0_grant, bus.r1_grant} !== {e0, e1}) begin n_err++; $display("FAIL rand_grant t=%0d: got %b want %b", t, {bus.r0_grant, bus.r1_grant}, {e0, e1}); end
      erv = 2'b00;
      ed = '0;
      if (rq.size() > 0 && rq[0].due == t) begin
        r = rq.pop_front();
        erv = r.id ? 2'b01 : 2'b10;
        ed = r.d;
      end
      n_cmp++; if ({bus.r0_rvalid, bus.r1_rvalid} !== erv) begin n_err++; $display("FAIL rand_rvalid t=%0d: got %b want %b", t, {bus.r0_rvalid, bus.r1_rvalid}, erv); end
      if (erv != 2'b00) begin
        n_cmp++; if ((erv[1] ? bus.r0_rdata : bus.r1_rdata) !== ed) begin n_err++; $display("FAIL rand_rdata t=%0d: got %h want %h", t, erv[1] ? bus.r0_rdata : bus.r1_rdata, ed); end
      end
      if (wq.size() > 0 && wq[0].due == t) begin
        w = wq.pop_front();
        n_cmp++; if ({bus.sram_oe, bus.sram_wdata} !== {1'b1, w.d}) begin n_err++; $display("FAIL rand_write t=%0d: got oe=%b wdata=%h want 1 %h", t, bus.sram_oe, bus.sram_wdata, w.d); end
      end else begin
        n_cmp++; if (bus.sram_oe !== 1'b0) begin n_err++; $display("FAIL rand_oe t=%0d: got %b want 0", t, bus.sram_oe); end
      end
      if (e0 || e1) begin
        if (e0 ? bus.r0_we : bus.r1_we) begin
          rmem[(e0 ? bus.r0_addr[3:0] : bus.r1_addr[3:0])] = e0 ? bus.r0_wdata : bus.r1_wdata;
          wq.push_back('{t + 3, e0 ? bus.r0_wdata : bus.r1_wdata});
        end else rq.push_back('{t + 4, e1, rmem[(e0 ? bus.r0_addr[3:0] : bus.r1_addr[3:0])]});
        turn = e0;
        if (e0) p0 = 1'b0; else p1 = 1'b0;
      end
      tick;
    end
    n_cmp++; if (rq.size() + wq.size() != 0) begin n_err++; $display("FAIL rand_drain: got %0d outstanding want 0", rq.size() + wq.size()); end
  endtask
  initial begin
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
    repeat (3) tick;
    test_reset;
    test_single_read;
    test_single_write;
    test_contention;
    test_streaming;
    test_back_to_back;
    test_reset_midflight;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
